// File: rtl/pio_led_pkg.sv
// Shared constants for the LED PIO: register word addresses and the reset
// values of the control registers. Values wider than a particular instance
// are sliced down to the parameter widths in the top module.
package pio_led_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_SET        = 3'd1;
  localparam logic [2:0] ADDR_CLEAR      = 3'd2;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd3;
  localparam logic [2:0] ADDR_DUTY       = 3'd4;
  localparam logic [2:0] ADDR_BLINK_HALF = 3'd5;

  // Duty resets to full brightness so the LEDs show DATA straight out of reset
  localparam logic [31:0] DUTY_RESET       = 32'hFFFF_FFFF;
  localparam logic [31:0] BLINK_MASK_RESET = 32'h0000_0000;
  localparam logic [31:0] BLINK_HALF_RESET = 32'h0000_0000;

endpackage

// File: rtl/pio_led_blink_timer.sv
// Blink half-period timer. Counts 0..half_period-1 and toggles phase at the
// terminal count, so every half-period lasts exactly half_period cycles.
// A half_period of zero parks the timer with phase high (LEDs steady on).
// A reload (register write) restarts the count with phase high on the same
// edge, which also keeps a shrinking half_period from stranding the counter.
module pio_led_blink_timer #(
  parameter int BLINK_BITS = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BLINK_BITS-1:0] half_period,
  input  logic                  reload,
  output logic                  phase
);

  logic [BLINK_BITS-1:0] blink_cnt;

  // Half-period counter and phase toggle, restarted on reload or when disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (reload || (half_period == '0)) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == (half_period - BLINK_BITS'(1))) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_BITS'(1);
    end
  end

endmodule

// File: rtl/pio_led_pwm_blink.sv
// Avalon-MM LED output PIO with atomic set/clear, per-bit blink mask and a
// global PWM brightness duty. Reads are combinational (zero wait states).
// Build option PIO_LED_PWM_EN: when defined, the PWM counter and DUTY
// register exist; when undefined, address 4 reads 0, writes to it are
// dropped and the LEDs are gated by blink only.
module pio_led_pwm_blink
  import pio_led_pkg::*;
#(
  parameter int               WIDTH       = 9,
  parameter int               PWM_BITS    = 8,
  parameter int               BLINK_BITS  = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic                  wr_en;
  logic [WIDTH-1:0]      data_reg;
  logic [WIDTH-1:0]      blink_mask;
  logic [BLINK_BITS-1:0] blink_half;
  logic                  phase;
  logic                  pwm_on;
  logic                  unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign unused_wd = ^writedata;

  // Bus writes to DATA (direct, set, clear), blink mask and blink half-period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg   <= RESET_VALUE;
      blink_mask <= BLINK_MASK_RESET[WIDTH-1:0];
      blink_half <= BLINK_HALF_RESET[BLINK_BITS-1:0];
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:       data_reg   <= writedata[WIDTH-1:0];
        ADDR_SET:        data_reg   <= data_reg | writedata[WIDTH-1:0];
        ADDR_CLEAR:      data_reg   <= data_reg & ~writedata[WIDTH-1:0];
        ADDR_BLINK_MASK: blink_mask <= writedata[WIDTH-1:0];
        ADDR_BLINK_HALF: blink_half <= writedata[BLINK_BITS-1:0];
        default: ;
      endcase
    end
  end

  pio_led_blink_timer #(
    .BLINK_BITS (BLINK_BITS)
  ) u_blink_timer (
    .clk         (clk),
    .reset       (reset),
    .half_period (blink_half),
    .reload      (wr_en && (address == ADDR_BLINK_HALF)),
    .phase       (phase)
  );

`ifdef PIO_LED_PWM_EN
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;

  // Free-running PWM counter and DUTY register; a duty write never resets the counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty    <= DUTY_RESET[PWM_BITS-1:0];
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (wr_en && (address == ADDR_DUTY)) begin
        duty <= writedata[PWM_BITS-1:0];
      end
    end
  end

  // Full duty is special-cased so it never drops out for a cycle
  assign pwm_on = (duty == '1) || (pwm_cnt < duty);
`else
  assign pwm_on = 1'b1;
`endif

  // Combinational register read, zero-extended, quiet when not selected
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata = 32'(data_reg);
        ADDR_BLINK_MASK:                 readdata = 32'(blink_mask);
`ifdef PIO_LED_PWM_EN
        ADDR_DUTY:                       readdata = 32'(duty);
`endif
        ADDR_BLINK_HALF:                 readdata = 32'(blink_half);
        default:                         readdata = '0;
      endcase
    end
  end

  assign out_port = data_reg & {WIDTH{pwm_on}} & (~blink_mask | {WIDTH{phase}});

endmodule
